// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and default operand-count width for the accumulator sequencer
package acc_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLEAR = 2'b01,
    S_ACCUM = 2'b10,
    S_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/acc_op_counter.sv
// rtl/acc_op_counter.sv - operand counter for one run; flags the handshake that accepts the final operand
module acc_op_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // limit is never zero while inc can be high, so limit-1 cannot wrap in use
  assign last = inc && (count == limit - ONE);

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - control FSM running one accumulation run of n_ops operands (optional abort: ACC_SEQ_ABORT_EN)
module acc_sequencer
  import acc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
`ifdef ACC_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] n_ops,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             acc_en,
  output logic             acc_clr,
  input  logic             acc_ovf,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic             cnt_clear;
  logic             last;
  logic             abort_now;

`ifdef ACC_SEQ_ABORT_EN
  assign abort_now = abort && (state == S_CLEAR || state == S_ACCUM);
`else
  assign abort_now = 1'b0;
`endif

  assign acc_en = op_valid & op_ready;

  acc_op_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .clr   (clr),
    .clear (cnt_clear),
    .inc   (acc_en),
    .limit (n_lat),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      n_lat <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        n_lat <= n_ops;
      end
      if (cnt_clear) begin
        ovf <= 1'b0;
      end else if (acc_en) begin
        ovf <= ovf | acc_ovf;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    op_ready  = 1'b0;
    acc_clr   = 1'b0;
    done      = 1'b0;
    cnt_clear = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        busy    = 1'b1;
        // an aborted run leaves count/ovf of the previous run untouched
        cnt_clear = !abort_now;
        if (abort_now)            state_nxt = S_IDLE;
        else if (n_lat == '0)     state_nxt = S_DONE;
        else                      state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        busy     = 1'b1;
        op_ready = !abort_now;
        if (abort_now)  state_nxt = S_IDLE;
        else if (last)  state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// tb/tb_acc_sequencer.sv - scoreboard bench: stimulus queues expected acc_clr/acc_en/done events, monitor checks them
module tb_acc_sequencer;

  localparam int K_CLR  = 0;
  localparam int K_EN   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    bit chk;
    int cnt;
    int ov;
  } ev_t;

  logic       clk = 1'b0;
  logic       clr, abort, start, op_valid, acc_ovf;
  logic [3:0] n_ops;
  logic       op_ready, acc_en, acc_clr, busy, done, ovf;
  logic [3:0] count;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  bit  mon_en = 0;
  ev_t exp_q[$];

  acc_sequencer #(.CNT_W(4)) dut (
    .clk      (clk),
    .clr      (clr),
`ifdef ACC_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .start    (start),
    .n_ops    (n_ops),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .acc_ovf  (acc_ovf),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .count    (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int c, input bit chk, input int cnt, input int ov);
    ev_t e;
    e.kind = kind; e.cyc = c; e.chk = chk; e.cnt = cnt; e.ov = ov;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (e.chk) begin
        check("event_count", int'(count), e.cnt);
        check("event_ovf", int'(ovf), e.ov);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_clr === 1'b1) mon_event(K_CLR);
      if (acc_en === 1'b1)  mon_event(K_EN);
      if (done === 1'b1)    mon_event(K_DONE);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int k;
    logic [6:0] pat;
    pat = 7'b1011001;
    clr = 1'b1; abort = 1'b0; start = 1'b0; op_valid = 1'b0; acc_ovf = 1'b0; n_ops = 4'd0;
    tick(2);
    clr = 1'b0;
    mon_en = 1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_acc_en", acc_en, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_ovf", ovf, 0);
    check("rst_count", count, 0);
    tick();

    // continuous valid, 3 operands
    e0 = cyc; n_ops = 4'd3; start = 1'b1; op_valid = 1'b1;
    push(K_CLR, e0 + 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(K_EN, e0 + 2 + i, 1, i, 0);
    push(K_DONE, e0 + 5, 1, 3, 0);
    tick(); start = 1'b0;
    tick(5); op_valid = 1'b0;
    check("cont_count_hold", count, 3);
    check("cont_busy_idle", busy, 0);

    // gapped valid, 4 operands
    e0 = cyc; n_ops = 4'd4; start = 1'b1; op_valid = 1'b0;
    push(K_CLR, e0 + 1, 0, 0, 0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        push(K_EN, e0 + 2 + i, 1, k, 0);
        k++;
      end
    end
    push(K_DONE, e0 + 9, 1, 4, 0);
    tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(); op_valid = pat[i];
    end
    tick(3); op_valid = 1'b0;

    // zero-length run
    e0 = cyc; n_ops = 4'd0; start = 1'b1; op_valid = 1'b1;
    push(K_CLR, e0 + 1, 0, 0, 0);
    push(K_DONE, e0 + 2, 1, 0, 0);
    tick(); start = 1'b0;
    tick(2); op_valid = 1'b0;

    // start ignored in ACCUM and DONE, accepted in IDLE right after DONE
    e0 = cyc; n_ops = 4'd2; start = 1'b1; op_valid = 1'b0;
    push(K_CLR, e0 + 1, 0, 0, 0);
    push(K_EN, e0 + 4, 1, 0, 0);
    push(K_EN, e0 + 5, 1, 1, 0);
    push(K_DONE, e0 + 6, 1, 2, 0);
    push(K_CLR, e0 + 8, 1, 2, 0);
    push(K_EN, e0 + 9, 1, 0, 0);
    push(K_DONE, e0 + 10, 1, 1, 0);
    tick(); start = 1'b0;
    tick(); start = 1'b1; n_ops = 4'd7;
    tick();
    tick(); start = 1'b0; op_valid = 1'b1;
    tick();
    tick(); start = 1'b1; n_ops = 4'd0;
    tick(); n_ops = 4'd1;
    tick(); start = 1'b0;
    tick(3); op_valid = 1'b0;

    // sticky overflow, cleared by the next run's CLEAR
    e0 = cyc; n_ops = 4'd3; start = 1'b1; op_valid = 1'b1;
    push(K_CLR, e0 + 1, 0, 0, 0);
    push(K_EN, e0 + 2, 1, 0, 0);
    push(K_EN, e0 + 3, 1, 1, 0);
    push(K_EN, e0 + 4, 1, 2, 1);
    push(K_DONE, e0 + 5, 1, 3, 1);
    tick(); start = 1'b0;
    tick();
    tick(); acc_ovf = 1'b1;
    tick(); acc_ovf = 1'b0;
    tick(2);
    check("ovf_sticky_idle", ovf, 1);
    e0 = cyc; n_ops = 4'd1; start = 1'b1;
    push(K_CLR, e0 + 1, 1, 3, 1);
    push(K_EN, e0 + 2, 1, 0, 0);
    push(K_DONE, e0 + 3, 1, 1, 0);
    tick(); start = 1'b0;
    tick(3); op_valid = 1'b0;

    // clr mid-run drops the run
    e0 = cyc; n_ops = 4'd5; start = 1'b1; op_valid = 1'b1;
    push(K_CLR, e0 + 1, 0, 0, 0);
    push(K_EN, e0 + 2, 1, 0, 0);
    push(K_EN, e0 + 3, 1, 1, 1);
    tick(); start = 1'b0;
    tick(); acc_ovf = 1'b1;
    tick(); acc_ovf = 1'b0; clr = 1'b1;
    tick(); clr = 1'b0; op_valid = 1'b0;
    check("clr_mid_count", count, 0);
    check("clr_mid_busy", busy, 0);
    check("clr_mid_ovf", ovf, 0);
    tick(3);

`ifdef ACC_SEQ_ABORT_EN
    e0 = cyc; n_ops = 4'd5; start = 1'b1; op_valid = 1'b1;
    push(K_CLR, e0 + 1, 0, 0, 0);
    push(K_EN, e0 + 2, 1, 0, 0);
    push(K_EN, e0 + 3, 1, 1, 0);
    tick(); start = 1'b0;
    tick(2);
    tick(); abort = 1'b1;
    check("abort_acc_en", acc_en, 0);
    check("abort_op_ready", op_ready, 0);
    tick(); abort = 1'b0; op_valid = 1'b0;
    check("abort_count", count, 2);
    check("abort_busy", busy, 0);
    tick(3);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
